gray_counter_n: RTL and testbench
=================================

# gray_counter_n

Parametrised reflected-Gray-code counter, the successor to the fixed 3-bit Gray counter. It adds configurable width, up/down counting, parallel load, and wrap or saturate terminal behaviour. It also provides separate sticky overflow and underflow flags with explicit clear, a one-cycle terminal pulse, and a binary mirror of the count. It is used wherever the design needs a multi-bit pointer that changes one bit per step, such as cross-domain pointers and low-glitch position encoders.

## Interface
- WIDTH, 3: counter width in bits; legal range 2..16.
- SATURATE, 0: terminal mode. 0 = wrap around, 1 = hold at the end code.
- Clk  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset; has priority over every other input.
- En  input  1  count enable; one step per cycle while high.
- Up  input  1  direction. 1 = increment the Gray sequence, 0 = decrement.
- Load  input  1  parallel load strobe.
- LoadBin  input  WIDTH  binary value to load; it is converted to Gray internally.
- ClrFlags  input  1  clears Overflow and Underflow.
- Output  output  WIDTH  current Gray code (registered).
- Binary  output  WIDTH  binary equivalent of Output (registered, same cycle as Output).
- Overflow  output  1  sticky flag: set when an up-step crosses or hits the top of the sequence.
- Underflow  output  1  sticky flag: set when a down-step crosses or hits the bottom of the sequence.
- Term  output  1  one-cycle pulse on any overflow or underflow event.

## Operation
- Internal state: binary count B[WIDTH-1:0], Overflow, Underflow, Term.
- Output = B ^ (B >> 1). Both Output and Binary are driven from registers, never through combinational logic from the inputs.
- Sequence for WIDTH=3, Up=1: 000, 001, 011, 010, 110, 111, 101, 100, then wrap to 000. Up=0 traverses the same sequence in reverse.
- MAX = 2^WIDTH − 1 in binary; its Gray code is 1 followed by WIDTH−1 zeros.
- Per-cycle priority: Reset > Load > En.
  - Reset: B=0, Overflow=0, Underflow=0, Term=0.
  - Load: B=LoadBin. Flags are unchanged and Term=0. En is ignored that cycle.
  - En & Up & B≠MAX: B+1.
  - En & Up & B=MAX: if SATURATE=0, B=0; if SATURATE=1, B holds at MAX. In both modes Overflow=1 and Term=1.
  - En & !Up & B≠0: B−1.
  - En & !Up & B=0: if SATURATE=0, B=MAX; if SATURATE=1, B holds at 0. In both modes Underflow=1 and Term=1.
  - En=0: B holds and Term=0.
- In saturate mode, every further En step at the end code re-asserts the flag and Term each cycle.
- ClrFlags clears both sticky flags. If a terminal event occurs in the same cycle, the set wins for that flag only; the other flag is still cleared.
- ClrFlags together with Load: flags are cleared and the load takes effect.
- ClrFlags has no effect on B or Term.
- Direction may change on any cycle. There is no pipeline, so the next step simply uses the new Up value.
- Consecutive Output values differ in exactly one bit for every En step. This does not hold across a Load or Reset, or on a saturated hold, where Output does not change.

## Timing
- All outputs are 0 from the first rising edge with Reset=1. Before the first reset, registers initialise to 0.
- Latency: inputs sampled at edge N are visible on Output, Binary, flags and Term after edge N. This is one-cycle latency and there is no extra pipeline stage.
- Term is high for exactly the cycle following the terminal step, then returns low unless another terminal step follows.
- Reset asserted mid-count zeroes everything on that edge, regardless of En, Load or ClrFlags.
- Reset deassert: the first count step occurs on the first edge with Reset=0 and En=1.
- No combinational path exists from any input to any output.

## Test plan
- WIDTH=3, SATURATE=0: reset, then En=1, Up=1 for 9 cycles. Required response: Output is 001, 011, 010, 110, 111, 101, 100, 000, 001. Overflow rises at the 000 step and stays high. Term pulses once on that step. Binary tracks 1..7, 0, 1. Each step differs from the previous by exactly one bit.
- WIDTH=4, SATURATE=0: reset, then Up=0 for 1 cycle. Required response: Output=1000, Binary=1111, Underflow=1, Term=1, Overflow=0. Then ClrFlags=1 for 1 cycle with En=0: Underflow=0.
- WIDTH=3, SATURATE=1: Load LoadBin=6 (Output=101), then Up=1 for 3 cycles. Required response: Output is 100, 100, 100. Overflow=1 from the second step. Term is high on the 2nd and 3rd cycles.
- Priority check: Load=1, LoadBin=5, En=1, Up=1, ClrFlags=1 while Overflow=1. Required response: Output=111, Binary=101, Overflow=0, Term=0.
- Same-cycle clear versus set: WIDTH=3, B=7, Underflow=1, En=1, Up=1, ClrFlags=1. Required response: Output=000, Overflow=1, Underflow=0, Term=1.
- Reset mid-count with Load=1 and En=1 asserted: all outputs are 0 on that edge. After deassert with En=1, Output=001 after one edge.

Source files
------------

// File: rtl/gray_counter_n.sv
// Parametrised reflected-Gray counter with up/down, parallel load, wrap or
// saturate at the ends, sticky overflow/underflow flags and a terminal pulse.
module gray_counter_n #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadBin,
  input  logic             ClrFlags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Term
);

  localparam logic [WIDTH-1:0] MAX_BIN  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_BIN = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_BIN  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             ov_q;
  logic             un_q;
  logic             term_q;

  logic [WIDTH-1:0] bin_next;
  logic             hit_top;
  logic             hit_bot;

  // Terminal events only count when a step is actually taken (Load wins).
  always_comb begin
    hit_top  = 1'b0;
    hit_bot  = 1'b0;
    bin_next = bin_q;
    if (Load) begin
      bin_next = LoadBin;
    end else if (En) begin
      if (Up) begin
        if (bin_q == MAX_BIN) begin
          hit_top  = 1'b1;
          bin_next = SATURATE ? MAX_BIN : ZERO_BIN;
        end else begin
          bin_next = bin_q + ONE_BIN;
        end
      end else begin
        if (bin_q == ZERO_BIN) begin
          hit_bot  = 1'b1;
          bin_next = SATURATE ? ZERO_BIN : MAX_BIN;
        end else begin
          bin_next = bin_q - ONE_BIN;
        end
      end
    end
  end

  // Gray code is registered alongside the binary so Output has no input path.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q  <= ZERO_BIN;
      gray_q <= ZERO_BIN;
      ov_q   <= 1'b0;
      un_q   <= 1'b0;
      term_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= bin_next ^ (bin_next >> 1);
      ov_q   <= hit_top | (ov_q & ~ClrFlags);
      un_q   <= hit_bot | (un_q & ~ClrFlags);
      term_q <= hit_top | hit_bot;
    end
  end

  assign Output    = gray_q;
  assign Binary    = bin_q;
  assign Overflow  = ov_q;
  assign Underflow = un_q;
  assign Term      = term_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: three instances (3-bit wrap, 4-bit wrap, 3-bit
// saturate) share one stimulus stream and are checked against a count model.
module tb_gray_counter_n;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] load_bin = 4'd0;

  logic [2:0] a_out, a_bin;
  logic       a_ov, a_un, a_t;
  logic [3:0] b_out, b_bin;
  logic       b_ov, b_un, b_t;
  logic [2:0] c_out, c_bin;
  logic       c_ov, c_un, c_t;

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) dut_a (
    .Clk(Clk), .Reset(rst), .En(en), .Up(up), .Load(load),
    .LoadBin(load_bin[2:0]), .ClrFlags(clr),
    .Output(a_out), .Binary(a_bin), .Overflow(a_ov), .Underflow(a_un), .Term(a_t)
  );

  gray_counter_n #(.WIDTH(4), .SATURATE(1'b0)) dut_b (
    .Clk(Clk), .Reset(rst), .En(en), .Up(up), .Load(load),
    .LoadBin(load_bin), .ClrFlags(clr),
    .Output(b_out), .Binary(b_bin), .Overflow(b_ov), .Underflow(b_un), .Term(b_t)
  );

  gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) dut_c (
    .Clk(Clk), .Reset(rst), .En(en), .Up(up), .Load(load),
    .LoadBin(load_bin[2:0]), .ClrFlags(clr),
    .Output(c_out), .Binary(c_bin), .Overflow(c_ov), .Underflow(c_un), .Term(c_t)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int failures = 0;

  int wd[3]  = '{3, 4, 3};
  int sat[3] = '{0, 0, 1};
  int m_b[3], m_ov[3], m_un[3], m_t[3];
  logic [3:0] exp_q[$];
  logic [2:0] prev_a;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  // Counts as plain integers modulo 2^WIDTH; flags follow the event rules.
  task automatic model_step(input logic r, input logic l, input logic [3:0] lb,
                            input logic e, input logic u, input logic c);
    for (int k = 0; k < 3; k++) begin
      int top;
      bit ev_o, ev_u;
      top  = (1 << wd[k]) - 1;
      ev_o = 0;
      ev_u = 0;
      if (r) begin
        m_b[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_t[k] = 0;
      end else begin
        if (l) begin
          m_b[k] = int'(lb) % (top + 1);
        end else if (e && u) begin
          if (m_b[k] == top) begin
            ev_o = 1;
            m_b[k] = sat[k] ? top : 0;
          end else m_b[k] = m_b[k] + 1;
        end else if (e && !u) begin
          if (m_b[k] == 0) begin
            ev_u = 1;
            m_b[k] = sat[k] ? 0 : top;
          end else m_b[k] = m_b[k] - 1;
        end
        if (c) begin
          m_ov[k] = 0; m_un[k] = 0;
        end
        if (ev_o) m_ov[k] = 1;
        if (ev_u) m_un[k] = 1;
        m_t[k] = (ev_o || ev_u) ? 1 : 0;
      end
    end
  endtask

  task automatic get_act(input int k, output int o, output int bn, output int ov,
                         output int un, output int t);
    case (k)
      0: begin o = int'(a_out); bn = int'(a_bin); ov = int'(a_ov); un = int'(a_un); t = int'(a_t); end
      1: begin o = int'(b_out); bn = int'(b_bin); ov = int'(b_ov); un = int'(b_un); t = int'(b_t); end
      default: begin o = int'(c_out); bn = int'(c_bin); ov = int'(c_ov); un = int'(c_un); t = int'(c_t); end
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic l, input logic [3:0] lb,
                       input logic e, input logic u, input logic c);
    int o, bn, ov, un, t;
    logic [3:0] exp_g;
    prev_a   = a_out;
    rst      = r;
    load     = l;
    load_bin = lb;
    en       = e;
    up       = u;
    clr      = c;
    @(posedge Clk);
    #1;
    model_step(r, l, lb, e, u, c);
    exp_q.push_back(4'(gray_of(m_b[0])));
    for (int k = 0; k < 3; k++) begin
      get_act(k, o, bn, ov, un, t);
      if (k == 0) begin
        exp_g = exp_q.pop_front();
        chk("m0_out", o, int'(exp_g));
      end else begin
        chk($sformatf("m%0d_out", k), o, gray_of(m_b[k]));
      end
      chk($sformatf("m%0d_bin", k), bn, m_b[k]);
      chk($sformatf("m%0d_ov", k), ov, m_ov[k]);
      chk($sformatf("m%0d_un", k), un, m_un[k]);
      chk($sformatf("m%0d_term", k), t, m_t[k]);
    end
    if (!r && !l && e)
      chk("a_onebit", $countones(a_out ^ prev_a), 1);
  endtask

  typedef struct {
    logic       r, l;
    logic [3:0] lb;
    logic       e, u, c;
    logic [2:0] eo, eb;
    logic       eov, eun, et;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // 3-bit wrap expectations, written out by hand.
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b001, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b011, 3'd2, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b010, 3'd3, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b110, 3'd4, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b111, 3'd5, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b101, 3'd6, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b100, 3'd7, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b000, 3'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0});
    // load + en + clear while overflow set
    tbl.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 3'b111, 3'd5, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 3'b100, 3'd7, 1'b0, 1'b1, 1'b1});
    // same-cycle clear versus overflow set
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 3'b000, 3'd0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b001, 3'd1, 1'b1, 1'b0, 1'b0});
    // reset mid-count beats load/en/clear
    tbl.push_back('{1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 3'b001, 3'd1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 3'b001, 3'd1, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 3; i++) begin
      m_b[i] = 0; m_ov[i] = 0; m_un[i] = 0; m_t[i] = 0;
    end
    prev_a = 3'd0;

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].l, tbl[i].lb, tbl[i].e, tbl[i].u, tbl[i].c);
      chk($sformatf("vec%0d_out", i), int'(a_out), int'(tbl[i].eo));
      chk($sformatf("vec%0d_bin", i), int'(a_bin), int'(tbl[i].eb));
      chk($sformatf("vec%0d_ov", i), int'(a_ov), int'(tbl[i].eov));
      chk($sformatf("vec%0d_un", i), int'(a_un), int'(tbl[i].eun));
      chk($sformatf("vec%0d_term", i), int'(a_t), int'(tbl[i].et));
    end

    // 4-bit wrap: single down step from zero, then clear.
    cycle(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("w4_under_out", int'(b_out), 8);
    chk("w4_under_bin", int'(b_bin), 15);
    chk("w4_under_un", int'(b_un), 1);
    chk("w4_under_term", int'(b_t), 1);
    chk("w4_under_ov", int'(b_ov), 0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("w4_clear_un", int'(b_un), 0);
    chk("w4_clear_term", int'(b_t), 0);

    // 3-bit saturate: load 6, then three up steps pinned at the top.
    cycle(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    chk("sat_load_out", int'(c_out), 5);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("sat_s1_out", int'(c_out), 4);
    chk("sat_s1_ov", int'(c_ov), 0);
    chk("sat_s1_term", int'(c_t), 0);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("sat_s2_out", int'(c_out), 4);
    chk("sat_s2_ov", int'(c_ov), 1);
    chk("sat_s2_term", int'(c_t), 1);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("sat_s3_out", int'(c_out), 4);
    chk("sat_s3_bin", int'(c_bin), 7);
    chk("sat_s3_term", int'(c_t), 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic r, l, e, u, c;
      logic [3:0] lb;
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = ($urandom_range(0, 2) != 0) ^ (i >= 300);
      c  = ($urandom_range(0, 7) == 0);
      lb = 4'($urandom_range(0, 15));
      cycle(r, l, lb, e, u, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
